ext_sram_ctrl: RTL

Far-end responder for the MMU's byte-wide external SRAM request port. It drives the pins of an off-chip asynchronous 8-bit SRAM.
- Reads are served in the same cycle: pass-through from the pad, or forwarded from a write-posting buffer.
- Writes are posted into a small FIFO. A drain FSM retires them to the chip with multi-cycle WE_n timing.
- Reads always win the pins. Nothing ever stalls the MMU.

---
 rtl/ext_sram_pkg.sv | 28 ++
 rtl/ext_sram_wbuf.sv | 80 ++++++++
 rtl/ext_sram_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ext_sram_pkg.sv
// Shared types and constants for the external byte-wide SRAM responder.
package ext_sram_pkg;

    // Default chip address width (512 KiB part).
    localparam int unsigned ADDR_W_DEF = 19;

    // Posted-write entries keep the full request width; bits above the chip
    // width are always stored as zero, so matching on them is harmless.
    localparam int unsigned ADDR_MAX_W = 32;

    typedef struct packed {
        logic [ADDR_MAX_W-1:0] addr;
        logic [7:0]            data;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        W_IDLE  = 2'b00,
        W_SETUP = 2'b01,
        W_PULSE = 2'b10,
        W_HOLD  = 2'b11
    } drain_state_e;

    // True in every drain state that owns the pins and drives the write bus.
    function automatic logic drives_write_bus(input drain_state_e s);
        return (s == W_SETUP) || (s == W_PULSE) || (s == W_HOLD);
    endfunction

endpackage

// File: rtl/ext_sram_wbuf.sv
// Posted-write FIFO with youngest-match read forwarding.
module ext_sram_wbuf
    import ext_sram_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  wbuf_entry_t           push_entry_i,
    input  logic                  pop_i,
    output wbuf_entry_t           head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [PTR_W:0]        count_o,
    input  logic [ADDR_MAX_W-1:0] lookup_addr_i,
    output logic                  hit_o,
    output logic [7:0]            hit_data_o
);

    wbuf_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic [PTR_W-1:0] idx_s;
    logic             match_s;

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Occupancy update: simultaneous push and pop leave the count unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and wrapping pointers; the caller only pushes when there is room.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Walk oldest to youngest so the last valid match (youngest) wins.
    always_comb begin
        hit_o      = 1'b0;
        hit_data_o = 8'h00;
        idx_s      = '0;
        match_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s      = rd_ptr_q + PTR_W'(i);
            match_s    = ((PTR_W+1)'(i) < count_q) && (mem_q[idx_s].addr == lookup_addr_i);
            hit_o      = hit_o | match_s;
            hit_data_o = match_s ? mem_q[idx_s].data : hit_data_o;
        end
    end

endmodule

// File: rtl/ext_sram_ctrl.sv
// External asynchronous SRAM responder: same-cycle reads, posted writes
// drained with multi-cycle WE_n timing, reads always own the pins.
module ext_sram_ctrl
    import ext_sram_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned WBUF_DEPTH = 4,
    parameter int unsigned WR_SETUP   = 1,
    parameter int unsigned WR_PULSE   = 1
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              ext_sram_read_i,
    input  logic              ext_sram_write_i,
    input  logic [31:0]       ext_sram_addr_i,
    input  logic [7:0]        ext_sram_wdata_i,
    output logic [7:0]        ext_sram_rdata_o,
    output logic [ADDR_W-1:0] sram_a_o,
    input  logic [7:0]        sram_dq_i,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe_o,
    output logic              sram_ce_no,
    output logic              sram_oe_no,
    output logic              sram_we_no,
    output logic              wbuf_empty_o,
    output logic              overflow_o
);

    localparam int unsigned PTR_W     = $clog2(WBUF_DEPTH);
    localparam int unsigned PHASE_MAX = (WR_SETUP > WR_PULSE) ? WR_SETUP : WR_PULSE;
    localparam int unsigned CNT_W     = $clog2(PHASE_MAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(WR_SETUP - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(WR_PULSE - 1);

    drain_state_e          state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  overflow_q;

    wbuf_entry_t           head_s;
    wbuf_entry_t           push_entry_s;
    logic                  full_s;
    logic                  empty_s;
    logic [PTR_W:0]        count_s;
    logic                  hit_s;
    logic [7:0]            hit_data_s;
    logic [ADDR_MAX_W-1:0] req_addr_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic                  start_s;
    logic                  more_after_pop_s;
    logic                  unused_addr_s;

    // Upper request bits never reach the chip or the forwarding compare.
    assign req_addr_s    = ADDR_MAX_W'(ext_sram_addr_i[ADDR_W-1:0]);
    assign unused_addr_s = ^{ext_sram_addr_i[31:ADDR_W], head_s.addr[ADDR_MAX_W-1:ADDR_W]};
    assign push_entry_s  = '{addr: req_addr_s, data: ext_sram_wdata_i};

    // The head retires at the end of the hold cycle whether or not a read is present.
    assign pop_s  = (state_q == W_HOLD);
    assign push_s = ext_sram_write_i && (!full_s || pop_s);
    assign drop_s = ext_sram_write_i && full_s && !pop_s;

    // A push into an empty buffer starts the drain on the very next cycle.
    assign start_s          = !empty_s || push_s;
    assign more_after_pop_s = (count_s > (PTR_W+1)'(1)) || push_s;

    ext_sram_wbuf #(
        .DEPTH (WBUF_DEPTH)
    ) u_wbuf (
        .clk           (clk),
        .rst_ni        (rst_ni),
        .push_i        (push_s),
        .push_entry_i  (push_entry_s),
        .pop_i         (pop_s),
        .head_o        (head_s),
        .full_o        (full_s),
        .empty_o       (empty_s),
        .count_o       (count_s),
        .lookup_addr_i (req_addr_s),
        .hit_o         (hit_s),
        .hit_data_o    (hit_data_s)
    );

    // Drain sequencer and sticky overflow; a read before the WE_n rising edge restarts the write.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q    <= W_IDLE;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (drop_s) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                W_IDLE: begin
                    cnt_q   <= '0;
                    state_q <= start_s ? W_SETUP : W_IDLE;
                end
                W_SETUP: begin
                    if (ext_sram_read_i) begin
                        cnt_q   <= '0;
                        state_q <= W_SETUP;
                    end else if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= W_PULSE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= W_SETUP;
                    end
                end
                W_PULSE: begin
                    if (ext_sram_read_i) begin
                        cnt_q   <= '0;
                        state_q <= W_SETUP;
                    end else if (cnt_q == PULSE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= W_HOLD;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= W_PULSE;
                    end
                end
                W_HOLD: begin
                    cnt_q   <= '0;
                    state_q <= more_after_pop_s ? W_SETUP : W_IDLE;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Pin mux: a read takes the pins outright, otherwise the drain state decides.
    always_comb begin
        sram_a_o     = '0;
        sram_dq_o    = 8'h00;
        sram_dq_oe_o = 1'b0;
        sram_ce_no   = 1'b1;
        sram_oe_no   = 1'b1;
        sram_we_no   = 1'b1;
        if (ext_sram_read_i) begin
            sram_a_o   = ext_sram_addr_i[ADDR_W-1:0];
            sram_ce_no = 1'b0;
            sram_oe_no = 1'b0;
        end else if (drives_write_bus(state_q)) begin
            sram_a_o     = head_s.addr[ADDR_W-1:0];
            sram_dq_o    = head_s.data;
            sram_dq_oe_o = 1'b1;
            sram_ce_no   = 1'b0;
            sram_we_no   = (state_q == W_PULSE) ? 1'b0 : 1'b1;
        end else begin
            sram_a_o = '0;
        end
    end

    // Read data: a pending posted write shadows the chip, same-cycle writes do not.
    assign ext_sram_rdata_o = (ext_sram_read_i && hit_s) ? hit_data_s : sram_dq_i;
    assign wbuf_empty_o     = empty_s;
    assign overflow_o       = overflow_q;

endmodule
